// File: rtl/bg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bg_pkg
//  Description : Shared constants, types and helpers for the scrolling
//                background fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package bg_pkg;

    // Palette index used for blanking and for clamped out-of-range pixels.
    localparam int BG_BORDER_DEFAULT   = 0;

    // Default raster geometry and the source image size derived from it.
    localparam int BG_SCREEN_W_DEFAULT = 640;
    localparam int BG_SCREEN_H_DEFAULT = 480;
    localparam int BG_SCALE_DEFAULT    = 1;
    localparam int BG_SRC_W_DEFAULT    = BG_SCREEN_W_DEFAULT >> BG_SCALE_DEFAULT;
    localparam int BG_SRC_H_DEFAULT    = BG_SCREEN_H_DEFAULT >> BG_SCALE_DEFAULT;
    localparam int BG_ADDR_W_DEFAULT   = $clog2(BG_SRC_W_DEFAULT * BG_SRC_H_DEFAULT);

    // Flags that travel alongside the ROM address until the ROM data returns.
    typedef struct packed {
        logic active;
        logic oob;
    } bg_flags_t;

    // Input-to-output latency: address register, ROM read, output register.
    function automatic int bg_latency(input int rom_latency);
        return rom_latency + 2;
    endfunction

    // Source image dimension for a given screen dimension and scale shift.
    function automatic int bg_src_dim(input int screen_dim, input int scale_shift);
        return screen_dim >> scale_shift;
    endfunction

endpackage : bg_pkg
`default_nettype wire

// File: rtl/bg_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : bg_delay_line
//  Description : Parametrised shift register with asynchronous reset. Carries
//                per-pixel flags in step with the external ROM read.
//  Revision    : 1.0 - initial release
// ============================================================================
module bg_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Next state: each stage takes the value of the stage before it.
    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Shift on every clock; reset clears every stage at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule : bg_delay_line
`default_nettype wire

// File: rtl/scroll_background_controller.sv
`default_nettype none
// ============================================================================
//  Module      : scroll_background_controller
//  Description : Maps the raster position to a background ROM address with
//                integer down-scaling, double-buffered X/Y scroll and wrap or
//                clamp edge handling. Output is registered with a valid flag
//                at a fixed latency of ROM_LATENCY+2 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module scroll_background_controller
    import bg_pkg::*;
#(
    parameter int SCREEN_W    = BG_SCREEN_W_DEFAULT,
    parameter int SCREEN_H    = BG_SCREEN_H_DEFAULT,
    parameter int SCALE_SHIFT = BG_SCALE_DEFAULT,
    parameter int PIXEL_BITS  = 4,
    parameter int ROM_LATENCY = 1,
    parameter int WRAP_MODE   = 1,
    parameter int BORDER      = BG_BORDER_DEFAULT
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [$clog2(SCREEN_W)-1:0]            hcount,
    input  logic [$clog2(SCREEN_H)-1:0]            vcount,
    input  logic                                   active,
    input  logic                                   frame_start,
    input  logic                                   scroll_we,
    input  logic [$clog2(SCREEN_W>>SCALE_SHIFT)-1:0] scroll_x_in,
    input  logic [$clog2(SCREEN_H>>SCALE_SHIFT)-1:0] scroll_y_in,
    output logic [$clog2((SCREEN_W>>SCALE_SHIFT)*(SCREEN_H>>SCALE_SHIFT))-1:0] rom_addr,
    input  logic [PIXEL_BITS-1:0]                  rom_data,
    output logic [PIXEL_BITS-1:0]                  background_pixel,
    output logic                                   pixel_valid,
    output logic                                   scroll_err
);

    localparam int SRC_W     = bg_src_dim(SCREEN_W, SCALE_SHIFT);
    localparam int SRC_H     = bg_src_dim(SCREEN_H, SCALE_SHIFT);
    localparam int XW        = $clog2(SRC_W);
    localparam int YW        = $clog2(SRC_H);
    localparam int AW        = $clog2(SRC_W * SRC_H);
    localparam int LAT       = bg_latency(ROM_LATENCY);
    // The flag path is one stage shorter than LAT: the output register is
    // shared with the pixel data.
    localparam int DLY_DEPTH = LAT - 1;

    localparam logic [XW:0]           C_SRC_W  = (XW+1)'(SRC_W);
    localparam logic [YW:0]           C_SRC_H  = (YW+1)'(SRC_H);
    localparam logic [PIXEL_BITS-1:0] C_BORDER = PIXEL_BITS'(BORDER);

    // Scroll registers: pending pair written by the CPU, live pair used by the raster.
    logic [XW-1:0] pending_x_q, pending_x_d;
    logic [YW-1:0] pending_y_q, pending_y_d;
    logic [XW-1:0] live_x_q,    live_x_d;
    logic [YW-1:0] live_y_q,    live_y_d;
    logic          scroll_err_q, scroll_err_d;

    // Pipeline registers.
    logic [AW-1:0]         rom_addr_q,         rom_addr_d;
    logic [PIXEL_BITS-1:0] background_pixel_q, background_pixel_d;
    logic                  pixel_valid_q,      pixel_valid_d;

    // Combinational datapath.
    logic          w_legal;
    logic [XW-1:0] w_eff_x;
    logic [YW-1:0] w_eff_y;
    logic [XW-1:0] w_hsrc;
    logic [YW-1:0] w_vsrc;
    logic [XW:0]   w_sx_raw, w_sx_wrap;
    logic [YW:0]   w_sy_raw, w_sy_wrap;
    logic [XW-1:0] w_sx;
    logic [YW-1:0] w_sy;
    logic          w_oob;
    bg_flags_t     w_flags_in, w_flags_out;

    // Write legality, and the scroll pair seen by a pixel sampled this cycle
    // (a frame_start cycle already sees the values it is about to latch).
    always_comb begin
        w_legal = ({1'b0, scroll_x_in} < C_SRC_W) && ({1'b0, scroll_y_in} < C_SRC_H);
        w_eff_x = live_x_q;
        w_eff_y = live_y_q;
        if (frame_start) begin
            if (scroll_we && w_legal) begin
                w_eff_x = scroll_x_in;
                w_eff_y = scroll_y_in;
            end else begin
                w_eff_x = pending_x_q;
                w_eff_y = pending_y_q;
            end
        end
    end

    // Scale, scroll and fold the raster position into the source image.
    // Both addends are below the source dimension, so one subtract suffices.
    always_comb begin
        w_hsrc    = XW'(hcount >> SCALE_SHIFT);
        w_vsrc    = YW'(vcount >> SCALE_SHIFT);
        w_sx_raw  = {1'b0, w_hsrc} + {1'b0, w_eff_x};
        w_sy_raw  = {1'b0, w_vsrc} + {1'b0, w_eff_y};
        w_sx_wrap = (w_sx_raw >= C_SRC_W) ? (w_sx_raw - C_SRC_W) : w_sx_raw;
        w_sy_wrap = (w_sy_raw >= C_SRC_H) ? (w_sy_raw - C_SRC_H) : w_sy_raw;
        w_sx      = w_sx_wrap[XW-1:0];
        w_sy      = w_sy_wrap[YW-1:0];
        // Clamp mode still wraps the address so the ROM is never read out of range.
        w_oob     = (WRAP_MODE == 0) && ((w_sx_raw >= C_SRC_W) || (w_sy_raw >= C_SRC_H));
        w_flags_in.active = active;
        w_flags_in.oob    = w_oob;
    end

    // Next-state logic for scroll registers and the pipeline.
    always_comb begin
        pending_x_d  = pending_x_q;
        pending_y_d  = pending_y_q;
        live_x_d     = live_x_q;
        live_y_d     = live_y_q;
        scroll_err_d = scroll_we && !w_legal;
        if (scroll_we && w_legal) begin
            pending_x_d = scroll_x_in;
            pending_y_d = scroll_y_in;
        end
        if (frame_start) begin
            live_x_d = w_eff_x;
            live_y_d = w_eff_y;
        end
        rom_addr_d         = AW'(w_sy) * AW'(SRC_W) + AW'(w_sx);
        background_pixel_d = (w_flags_out.active && !w_flags_out.oob) ? rom_data : C_BORDER;
        pixel_valid_d      = w_flags_out.active;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_x_q        <= '0;
            pending_y_q        <= '0;
            live_x_q           <= '0;
            live_y_q           <= '0;
            scroll_err_q       <= 1'b0;
            rom_addr_q         <= '0;
            background_pixel_q <= C_BORDER;
            pixel_valid_q      <= 1'b0;
        end else begin
            pending_x_q        <= pending_x_d;
            pending_y_q        <= pending_y_d;
            live_x_q           <= live_x_d;
            live_y_q           <= live_y_d;
            scroll_err_q       <= scroll_err_d;
            rom_addr_q         <= rom_addr_d;
            background_pixel_q <= background_pixel_d;
            pixel_valid_q      <= pixel_valid_d;
        end
    end

    bg_delay_line #(
        .WIDTH ($bits(bg_flags_t)),
        .DEPTH (DLY_DEPTH)
    ) u_flag_delay (
        .clk   (clk),
        .reset (reset),
        .din   (w_flags_in),
        .dout  (w_flags_out)
    );

    assign rom_addr         = rom_addr_q;
    assign background_pixel = background_pixel_q;
    assign pixel_valid      = pixel_valid_q;
    assign scroll_err       = scroll_err_q;

endmodule : scroll_background_controller
`default_nettype wire
